qkd_sift_reader: RTL and testbench
==================================

QKD_SIFT_READER -- requirements
Module: qkd_sift_reader

Interface
REQ-001 Parameter NUM_CELLS, default 16, SHALL set the number of collapse cells in the bank; legal range 2..256.
REQ-002 Parameter SEL_W, default $clog2(NUM_CELLS), SHALL set the cell-select width.
REQ-003 clk  input  1  SHALL be the clock, rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a sifting session; it is sampled only in IDLE.
REQ-006 abort  input  1  SHALL be a request to terminate the session and kill the selected cell.
REQ-007 cell_sel  output  SEL_W  SHALL be the index of the targeted cell.
REQ-008 cell_init  output  1  SHALL be the init strobe to the selected cell.
REQ-009 cell_read  output  1  SHALL be the read/measure strobe to the selected cell.
REQ-010 cell_basis  output  2  SHALL be the measurement basis presented with cell_read.
REQ-011 cell_fuse_blow  output  1  SHALL be the kill request to the selected cell.
REQ-012 cell_value  input  8  SHALL be the same-cycle read data from the selected cell.
REQ-013 cell_oe  input  1  SHALL be the same-cycle valid pulse from the selected cell on an authorized read.
REQ-014 cell_fuse_fire  input  1  SHALL be the collapse pulse from the selected cell, one cycle after a live read.
REQ-015 key_data  output  8  SHALL be the sifted key byte.
REQ-016 key_valid  output  1  SHALL indicate that key_data is valid; it follows valid/ready rules.
REQ-017 key_ready  input  1  SHALL indicate that the consumer accepts key_data.
REQ-018 busy / done / aborted  outputs  1 each  SHALL report the session state.
REQ-019 match_count, miss_count, dead_count  outputs  SEL_W+1 each  SHALL report per-session statistics.

Function
REQ-020 The FSM SHALL have the states IDLE, ARM, SETTLE, MEASURE, CHECK, EMIT, DONE.
REQ-021 IDLE & start -> ARM; round index ← 0; all counters ← 0; aborted ← 0.
REQ-022 ARM SHALL assert cell_init for exactly one cycle, then transition to SETTLE.
REQ-023 SETTLE SHALL last one idle cycle (cell load completes), then transition to MEASURE.
REQ-024 MEASURE SHALL assert cell_read for one cycle with cell_basis = basis_lfsr[1:0] sampled that cycle; cell_value is captured into key_reg iff cell_oe = 1; then -> CHECK.
REQ-025 The basis LFSR SHALL be 8 bits, seed 8'h3C on reset, next = {l[6:0], l[7]^l[5]^l[4]^l[3]}, and SHALL advance every cycle.
REQ-026 In CHECK, cell_fuse_fire = 0 SHALL increment dead_count (cell already collapsed or fused); in that case any capture is discarded and counted as a miss.
REQ-027 CHECK with a valid capture SHALL increment match_count and go to EMIT; otherwise it SHALL increment miss_count and end the round.
REQ-028 EMIT SHALL hold key_valid = 1 and key_data stable until key_ready = 1; the handshake completes on the edge where key_valid & key_ready, and ends the round.
REQ-029 Round end SHALL go to DONE if the round index = NUM_CELLS-1; otherwise it SHALL increment the round index and go to ARM.
REQ-030 cell_sel SHALL equal the round index in every non-IDLE state.
REQ-031 DONE SHALL pulse done for one cycle, then go to IDLE; counters hold until the next start.
REQ-032 abort in any non-IDLE state SHALL pulse cell_fuse_blow for one cycle, set aborted, drop key_valid, and go to IDLE the next cycle; abort in the same cycle as a completing handshake takes priority, and the byte counts as delivered.
REQ-033 abort in IDLE, and start while not IDLE, SHALL be ignored.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 Cell strobes SHALL be mutually exclusive and SHALL be zero outside their states.
REQ-036 Counters SHALL never wrap, because their max is NUM_CELLS and the width is SEL_W+1.

Reset
REQ-037 On reset the block SHALL enter IDLE, and all outputs, counters, key_reg and aborted SHALL be 0.
REQ-038 Reset mid-session SHALL drop all strobes asynchronously; no cell_fuse_blow is issued.

Structure
REQ-039 The package qkd_pkg SHALL hold the state enum type, LFSR seed/taps constants, and the basis type (2-bit).
REQ-040 Sub-module qkd_basis_lfsr SHALL implement the basis LFSR, with clk/reset inputs and an 8-bit state output.

Verification
REQ-041 Cell model matches basis on every cell; start -> 16 key bytes delivered with key_ready = 1, match_count = 16, miss_count = 0, dead_count = 0, then a done pulse.
REQ-042 Model with basis mismatch on odd cells -> 8 bytes out, match_count = 8, miss_count = 8.
REQ-043 Cell 3 pre-fused (no fuse_fire, oe = 0) -> dead_count = 1, miss_count ≥ 1, no byte emitted for round 3.
REQ-044 key_ready held 0 for 5 cycles in EMIT -> key_valid stays 1, key_data unchanged, cell_sel constant.
REQ-045 abort asserted during MEASURE of round 5 -> cell_fuse_blow = 1 for one cycle with cell_sel = 5, aborted = 1, IDLE next cycle, no done pulse.
REQ-046 reset asserted during EMIT -> key_valid = 0 and busy = 0 immediately; counters read 0.

Source files
------------

// File: rtl/qkd_pkg.sv
// Shared types and constants for the QKD sift reader and its basis LFSR.
package qkd_pkg;

  // Session FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_CHECK   = 3'd4,
    ST_EMIT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Measurement basis presented to a cell along with the read strobe.
  typedef logic [1:0] basis_t;

  localparam int         LFSR_W    = 8;
  localparam logic [7:0] LFSR_SEED = 8'h3C;
  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Debug view: FSM state plus the basis LFSR state.
  typedef struct packed {
    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
  } dbg_t;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/qkd_basis_lfsr.sv
// Free-running 8-bit LFSR whose low two bits pick the measurement basis.
module qkd_basis_lfsr
  import qkd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_lfsr;

  // Reseed on reset, otherwise advance every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/qkd_sift_reader.sv
// Sifting sequencer: walks a bank of collapse cells one round per cell,
// reads each with a pseudo-random basis and streams matching bytes out.
//
// Output handshake: key_valid rises with a byte on key_data and both stay
// stable until key_ready is sampled high; the transfer happens on the
// rising edge where key_valid & key_ready are both 1. An abort may drop
// key_valid without a transfer.
module qkd_sift_reader
  import qkd_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int SEL_W     = $clog2(NUM_CELLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [SEL_W-1:0] cell_sel,
  output logic             cell_init,
  output logic             cell_read,
  output basis_t           cell_basis,
  output logic             cell_fuse_blow,
  input  logic [7:0]       cell_value,
  input  logic             cell_oe,
  input  logic             cell_fuse_fire,
  output logic [7:0]       key_data,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [SEL_W:0]   match_count,
  output logic [SEL_W:0]   miss_count,
  output logic [SEL_W:0]   dead_count,
  output dbg_t             o_dbg
);

  localparam logic [SEL_W-1:0] LAST_ROUND = SEL_W'(NUM_CELLS - 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_round;
  logic [SEL_W:0]    r_match;
  logic [SEL_W:0]    r_miss;
  logic [SEL_W:0]    r_dead;
  logic [7:0]        r_key;
  logic              r_cap;
  logic              r_aborted;
  logic              r_fuse_blow;

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_last;
  state_t            w_end_state;
  logic [SEL_W-1:0]  w_next_round;

  qkd_basis_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .o_state (w_lfsr)
  );

  // Round end: finish after the last cell, otherwise move to the next cell.
  assign w_last       = (r_round == LAST_ROUND);
  assign w_end_state  = w_last ? ST_DONE : ST_ARM;
  assign w_next_round = w_last ? r_round : r_round + 1'b1;

  // Session FSM; abort wins over every non-idle transition, including a
  // handshake completing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_round     <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_dead      <= '0;
      r_key       <= '0;
      r_cap       <= 1'b0;
      r_aborted   <= 1'b0;
      r_fuse_blow <= 1'b0;
    end else begin
      r_fuse_blow <= 1'b0;
      if (r_state != ST_IDLE && abort) begin
        r_state     <= ST_IDLE;
        r_aborted   <= 1'b1;
        r_fuse_blow <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state   <= ST_ARM;
              r_round   <= '0;
              r_match   <= '0;
              r_miss    <= '0;
              r_dead    <= '0;
              r_cap     <= 1'b0;
              r_aborted <= 1'b0;
            end
          end
          ST_ARM:    r_state <= ST_SETTLE;
          ST_SETTLE: r_state <= ST_MEASURE;
          ST_MEASURE: begin
            r_cap <= cell_oe;
            if (cell_oe) r_key <= cell_value;
            r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (!cell_fuse_fire) begin
              // No collapse pulse: the cell was already dead, drop any capture.
              r_dead  <= r_dead + 1'b1;
              r_miss  <= r_miss + 1'b1;
              r_state <= w_end_state;
              r_round <= w_next_round;
            end else if (r_cap) begin
              r_match <= r_match + 1'b1;
              r_state <= ST_EMIT;
            end else begin
              r_miss  <= r_miss + 1'b1;
              r_state <= w_end_state;
              r_round <= w_next_round;
            end
          end
          ST_EMIT: begin
            if (key_ready) begin
              r_state <= w_end_state;
              r_round <= w_next_round;
            end
          end
          ST_DONE:  r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cell_sel       = r_round;
  assign cell_init      = (r_state == ST_ARM);
  assign cell_read      = (r_state == ST_MEASURE);
  assign cell_basis     = cell_read ? basis_t'(w_lfsr[1:0]) : basis_t'(2'b00);
  assign cell_fuse_blow = r_fuse_blow;
  assign key_data       = r_key;
  assign key_valid      = (r_state == ST_EMIT);
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign aborted        = r_aborted;
  assign match_count    = r_match;
  assign miss_count     = r_miss;
  assign dead_count     = r_dead;
  assign o_dbg          = '{state: r_state, lfsr: w_lfsr};

endmodule

// File: tb/tb_qkd_sift_reader.sv
// Directed bench for qkd_sift_reader with a behavioural cell bank and a
// queue of expected key bytes.
module tb_qkd_sift_reader;
  import qkd_pkg::*;

  localparam int N  = 16;
  localparam int SW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [SW-1:0] cell_sel;
  logic          cell_init;
  logic          cell_read;
  basis_t        cell_basis;
  logic          cell_fuse_blow;
  logic [7:0]    cell_value;
  logic          cell_oe;
  logic          cell_fuse_fire;
  logic [7:0]    key_data;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [SW:0]   match_count;
  logic [SW:0]   miss_count;
  logic [SW:0]   dead_count;
  dbg_t          o_dbg;

  int         n_vec;
  int         n_err;
  logic [7:0] exp_q[$];

  logic [7:0] vals     [N];
  logic       prefused [N];
  logic       mismatch [N];
  logic       live     [N];
  logic [7:0] m_lfsr;
  logic       fire_r;

  qkd_sift_reader #(.NUM_CELLS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cell_sel       (cell_sel),
    .cell_init      (cell_init),
    .cell_read      (cell_read),
    .cell_basis     (cell_basis),
    .cell_fuse_blow (cell_fuse_blow),
    .cell_value     (cell_value),
    .cell_oe        (cell_oe),
    .cell_fuse_fire (cell_fuse_fire),
    .key_data       (key_data),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .match_count    (match_count),
    .miss_count     (miss_count),
    .dead_count     (dead_count),
    .o_dbg          (o_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference basis sequence: seed 3C, feedback l7^l5^l4^l3.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'h3C;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Cell bank: a live cell collapses when read; it answers only when the
  // presented basis is the expected one and the cell is not a mismatch cell.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_r <= 1'b0;
    end else begin
      fire_r <= cell_read && live[cell_sel];
      if (!busy) begin
        for (int i = 0; i < N; i++) live[i] <= !prefused[i];
      end else if (cell_read) begin
        live[cell_sel] <= 1'b0;
      end
    end
  end

  assign cell_value     = vals[cell_sel];
  assign cell_oe        = cell_read && live[cell_sel] && !mismatch[cell_sel] &&
                          (cell_basis == m_lfsr[1:0]);
  assign cell_fuse_fire = fire_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup_bank(input bit odd_mismatch, input int dead_cell);
    for (int i = 0; i < N; i++) begin
      vals[i]     = 8'($urandom_range(0, 255));
      mismatch[i] = odd_mismatch && (i % 2 == 1);
      prefused[i] = (i == dead_cell);
    end
  endtask

  task automatic fill_expected(input int limit);
    exp_q.delete();
    for (int i = 0; i < limit; i++)
      if (!prefused[i] && !mismatch[i]) exp_q.push_back(vals[i]);
  endtask

  task automatic run_session(input int stall_r, input int abort_r, input int reset_r,
                             input int glitch_r, output int bytes, output int dones);
    logic [7:0] held;
    logic [7:0] exp_b;
    bit stalled;
    bit glitched;
    bit finished;
    bytes = 0; dones = 0; stalled = 0; glitched = 0; finished = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check("strobe_excl", 32'($countones({cell_init, cell_read, cell_fuse_blow}) <= 1), 32'd1);
      if (cell_read) check("basis", 32'(cell_basis), 32'(m_lfsr[1:0]));
      if (done) dones++;
      if (glitch_r >= 0 && busy && int'(cell_sel) == glitch_r && !glitched) begin
        start = 1'b1;
        glitched = 1;
      end
      if (stall_r >= 0 && key_valid && int'(cell_sel) == stall_r && !stalled) begin
        stalled = 1;
        key_ready = 1'b0;
        held = key_data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_valid", 32'(key_valid), 32'd1);
          check("stall_data", 32'(key_data), 32'(held));
          check("stall_sel", 32'(cell_sel), 32'(stall_r));
        end
        key_ready = 1'b1;
      end
      if (abort_r >= 0 && cell_read && int'(cell_sel) == abort_r) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_blow", 32'(cell_fuse_blow), 32'd1);
        check("abort_sel", 32'(cell_sel), 32'(abort_r));
        check("abort_flag", 32'(aborted), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_valid", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("abort_blow_1cyc", 32'(cell_fuse_blow), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        finished = 1;
      end else if (reset_r >= 0 && key_valid && int'(cell_sel) == reset_r) begin
        check("start_clears_aborted", 32'(aborted), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_match", 32'(match_count), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_dead", 32'(dead_count), 32'd0);
        check("rst_key", 32'(key_data), 32'd0);
        check("rst_blow", 32'(cell_fuse_blow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        finished = 1;
      end else if (key_valid && key_ready) begin
        check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("key_byte", 32'(key_data), 32'(exp_b));
        end
        bytes++;
      end else if (!busy) begin
        finished = 1;
      end
    end
    check("session_ended", 32'(finished), 32'd1);
  endtask

  initial begin
    int bytes;
    int dones;
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b1;
    setup_bank(0, -1);
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_state", 32'(o_dbg.state), 32'(ST_IDLE));
    check("rst_lfsr", 32'(o_dbg.lfsr), 32'h3C);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_sel0", 32'(cell_sel), 32'd0);
    check("rst_strobes", 32'({cell_init, cell_read, cell_fuse_blow, key_valid, done, aborted}), 32'd0);
    check("rst_counts", 32'({match_count, miss_count, dead_count}), 32'd0);
    check("rst_key0", 32'(key_data), 32'd0);
    reset = 1'b0;

    // All cells answer; round 2 stalls the consumer for 5 cycles.
    setup_bank(0, -1);
    fill_expected(N);
    run_session(2, -1, -1, -1, bytes, dones);
    check("s1_bytes", 32'(bytes), 32'd16);
    check("s1_done", 32'(dones), 32'd1);
    check("s1_match", 32'(match_count), 32'd16);
    check("s1_miss", 32'(miss_count), 32'd0);
    check("s1_dead", 32'(dead_count), 32'd0);
    check("s1_q_empty", 32'(exp_q.size()), 32'd0);
    check("s1_aborted", 32'(aborted), 32'd0);

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_flag", 32'(aborted), 32'd0);
    check("idle_abort_blow", 32'(cell_fuse_blow), 32'd0);
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Odd cells reject the basis; a stray start at round 7 is ignored.
    setup_bank(1, -1);
    fill_expected(N);
    run_session(-1, -1, -1, 7, bytes, dones);
    check("s2_bytes", 32'(bytes), 32'd8);
    check("s2_done", 32'(dones), 32'd1);
    check("s2_match", 32'(match_count), 32'd8);
    check("s2_miss", 32'(miss_count), 32'd8);
    check("s2_dead", 32'(dead_count), 32'd0);
    check("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // Cell 3 already fused.
    setup_bank(0, 3);
    fill_expected(N);
    run_session(-1, -1, -1, -1, bytes, dones);
    check("s3_bytes", 32'(bytes), 32'd15);
    check("s3_match", 32'(match_count), 32'd15);
    check("s3_miss", 32'(miss_count), 32'd1);
    check("s3_dead", 32'(dead_count), 32'd1);
    check("s3_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort during the measure of round 5.
    setup_bank(0, -1);
    fill_expected(5);
    run_session(-1, 5, -1, -1, bytes, dones);
    check("s4_bytes", 32'(bytes), 32'd5);
    check("s4_done", 32'(dones), 32'd0);
    check("s4_match", 32'(match_count), 32'd5);
    check("s4_q_empty", 32'(exp_q.size()), 32'd0);
    check("s4_aborted_hold", 32'(aborted), 32'd1);

    // Reset while a byte is offered in round 1.
    setup_bank(0, -1);
    fill_expected(N);
    run_session(-1, -1, 1, -1, bytes, dones);
    check("s5_bytes", 32'(bytes), 32'd1);
    @(negedge clk);
    check("s5_idle", 32'(o_dbg.state), 32'(ST_IDLE));
    check("s5_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
